// File: rtl/dm_pkg.sv
// ============================================================================
// Module   : dm_pkg
// Purpose  : Shared types and widths for the wait-state data-memory responder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package dm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } dm_state_e;

  localparam int DM_ADDR_W = 10;
  localparam int DM_DATA_W = 32;
  localparam int DM_BE_W   = DM_DATA_W / 8;
  localparam int DM_CNT_W  = 4;

endpackage

`default_nettype wire

// File: rtl/dm_array.sv
// ============================================================================
// Module   : dm_array
// Purpose  : Synchronous single-port word storage with per-byte write lanes;
//            read data is registered on en, contents are never reset.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dm_array
  import dm_pkg::*;
#(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 we,
  input  logic [DM_BE_W-1:0]   be,
  input  logic [ADDR_W-1:0]    addr,
  input  logic [DM_DATA_W-1:0] wdata,
  output logic [DM_DATA_W-1:0] dout
);

  // One independent byte-wide memory per lane keeps the masked write trivial.
  for (genvar i = 0; i < DM_BE_W; i++) begin : g_lane
    logic [7:0] r_lane [DEPTH];
    logic [7:0] r_dout;

    always_ff @(posedge clk) begin
      if (en && we && be[i]) begin
        r_lane[addr] <= wdata[8*i +: 8];
      end
    end

    // Read port register is the responder's visible rdata, so it is reset.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_dout <= 8'h00;
      end else if (en && !we) begin
        r_dout <= r_lane[addr];
      end
    end

    assign dout[8*i +: 8] = r_dout;
  end

endmodule

`default_nettype wire

// File: rtl/dm_wait_responder.sv
// ============================================================================
// Module   : dm_wait_responder
// Purpose  : req/ack data-memory responder with WAIT_CYCLES wait states.
//            Macro DM_WAIT_BYTE_EN enables byte-masked writes (else full word).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dm_wait_responder
  import dm_pkg::*;
#(
  parameter int WAIT_CYCLES = 2,
  parameter int DEPTH       = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req,
  input  logic                      we,
  input  logic [$clog2(DEPTH)-1:0]  addr,
  input  logic [DM_BE_W-1:0]        be,
  input  logic [DM_DATA_W-1:0]      wdata,
  output logic [DM_DATA_W-1:0]      rdata,
  output logic                      ack,
  output logic                      busy
);

  localparam int c_ADDR_W = $clog2(DEPTH);
  localparam logic [DM_CNT_W-1:0] c_CNT_INIT =
    DM_CNT_W'((WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0);

  dm_state_e               r_state;
  dm_state_e               w_state_nxt;
  logic [DM_CNT_W-1:0]     r_cnt;
  logic [DM_CNT_W-1:0]     w_cnt_nxt;
  logic                    w_latch;
  logic                    w_access;

  logic                    r_we;
  logic [c_ADDR_W-1:0]     r_addr;
  logic [DM_BE_W-1:0]      r_be;
  logic [DM_DATA_W-1:0]    r_wdata;

  logic                    w_arr_we;
  logic [c_ADDR_W-1:0]     w_arr_addr;
  logic [DM_BE_W-1:0]      w_arr_be;
  logic [DM_BE_W-1:0]      w_be_sel;
  logic [DM_DATA_W-1:0]    w_arr_wdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_be    <= '0;
      r_wdata <= '0;
    end else if (w_latch) begin
      r_we    <= we;
      r_addr  <= addr;
      r_be    <= be;
      r_wdata <= wdata;
    end
  end

  // w_access marks the edge that enters ACK; the array commits on that edge.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_latch     = 1'b0;
    w_access    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (req) begin
          w_latch = 1'b1;
          if (WAIT_CYCLES == 0) begin
            w_state_nxt = ACK;
            w_access    = 1'b1;
          end else begin
            w_state_nxt = WAIT;
            w_cnt_nxt   = c_CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (!req) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == '0) begin
          w_state_nxt = ACK;
          w_access    = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      ACK: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // With zero wait states the access happens on the accepting edge itself,
  // before the latch is loaded, so the live inputs feed the array directly.
  always_comb begin
    w_arr_we    = r_we;
    w_arr_addr  = r_addr;
    w_be_sel    = r_be;
    w_arr_wdata = r_wdata;
    if (r_state == IDLE) begin
      w_arr_we    = we;
      w_arr_addr  = addr;
      w_be_sel    = be;
      w_arr_wdata = wdata;
    end
  end

`ifdef DM_WAIT_BYTE_EN
  assign w_arr_be = w_be_sel;
`else
  assign w_arr_be = w_be_sel | {DM_BE_W{1'b1}};
`endif

  dm_array #(
    .DEPTH  (DEPTH),
    .ADDR_W (c_ADDR_W)
  ) u_array (
    .clk   (clk),
    .rst_n (rst),
    .en    (w_access),
    .we    (w_arr_we),
    .be    (w_arr_be),
    .addr  (w_arr_addr),
    .wdata (w_arr_wdata),
    .dout  (rdata)
  );

  assign ack  = (r_state == ACK);
  assign busy = (r_state != IDLE);

endmodule

`default_nettype wire
